// File: rtl/dma_spi_engine_pkg.sv
// Shared constants and types for the DMA/Z80 SPI master engine.
package dma_spi_engine_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DMA  = 2'd1,
      OWN_Z80  = 2'd2
   } owner_e;

   localparam logic       SPI_IDLE_MOSI  = 1'b1;
   localparam logic [7:0] SPI_RST_RDDATA = 8'hFF;
   localparam logic [3:0] LAST_HALF      = 4'd15;

endpackage

// File: rtl/dma_spi_engine_if.sv
// DMA-side byte transfer port of the SPI engine.
interface dma_spi_engine_if;

   logic       spi_req;
   logic [7:0] spi_wrdata;
   logic       spi_stb;
   logic [7:0] spi_rddata;

   modport master (
      output spi_req,
      output spi_wrdata,
      input  spi_stb,
      input  spi_rddata
   );

   modport slave (
      input  spi_req,
      input  spi_wrdata,
      output spi_stb,
      output spi_rddata
   );

endinterface

// File: rtl/dma_spi_engine_clk_div.sv
// Half-period divider: one-cycle tick every DIV enabled cycles, synchronous clear.
module dma_spi_engine_clk_div #(
   parameter int unsigned DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   logic [7:0] r_cnt;
   logic       w_wrap;

   assign w_wrap = (r_cnt == 8'(DIV - 1));
   assign o_tick = i_en & w_wrap;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/dma_spi_engine.sv
// Mode-0 MSB-first byte SPI master shared by the DMA (priority) and Z80 port writes.
module dma_spi_engine
   import dma_spi_engine_pkg::*;
#(
   parameter int unsigned DIV = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   dma_spi_engine_if.slave        io_dma,
   input  logic                   i_z_wr,
   input  logic [7:0]             i_zdata,
   output logic                   o_z_busy,
   output logic                   o_spi_sck,
   output logic                   o_spi_mosi,
   input  logic                   i_spi_miso
);

   logic [1:0] r_state;
   owner_e     r_owner;
   logic [7:0] r_shreg;
   logic [7:0] r_rx;
   logic [3:0] r_half;
   logic       r_sck;
   logic       r_mosi;
   logic       r_stb;
   logic [7:0] r_rddata;
   logic       w_tick;
   logic       w_shift;

   assign w_shift = (r_state == ST_SHIFT);

   dma_spi_engine_clk_div #(
      .DIV (DIV)
   ) u_clk_div (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (!w_shift),
      .i_en   (w_shift),
      .o_tick (w_tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_owner  <= OWN_NONE;
         r_shreg  <= '0;
         r_rx     <= '0;
         r_half   <= '0;
         r_sck    <= 1'b0;
         r_mosi   <= SPI_IDLE_MOSI;
         r_stb    <= 1'b0;
         r_rddata <= SPI_RST_RDDATA;
      end else begin
         r_stb <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // DMA wins a same-cycle collision; the Z80 write is simply dropped.
               if (io_dma.spi_req) begin
                  r_owner <= OWN_DMA;
                  r_shreg <= io_dma.spi_wrdata;
                  r_mosi  <= io_dma.spi_wrdata[7];
                  r_sck   <= 1'b0;
                  r_half  <= '0;
                  r_state <= ST_SHIFT;
               end else if (i_z_wr) begin
                  r_owner <= OWN_Z80;
                  r_shreg <= i_zdata;
                  r_mosi  <= i_zdata[7];
                  r_sck   <= 1'b0;
                  r_half  <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_tick) begin
                  r_sck  <= ~r_sck;
                  r_half <= r_half + 4'd1;
                  if (!r_sck) begin
                     r_rx <= {r_rx[6:0], i_spi_miso};
                  end else if (r_half == LAST_HALF) begin
                     r_mosi   <= SPI_IDLE_MOSI;
                     r_stb    <= (r_owner == OWN_DMA);
                     r_rddata <= r_rx;
                     r_state  <= ST_DONE;
                  end else begin
                     r_shreg <= {r_shreg[6:0], 1'b0};
                     r_mosi  <= r_shreg[6];
                  end
               end
            end
            ST_DONE: begin
               r_owner <= OWN_NONE;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign io_dma.spi_stb    = r_stb;
   assign io_dma.spi_rddata = r_rddata;
   assign o_z_busy          = (r_state != ST_IDLE) | io_dma.spi_req;
   assign o_spi_sck         = r_sck;
   assign o_spi_mosi        = r_mosi;

endmodule

// File: tb/tb_dma_spi_engine.sv
// Scoreboard bench for dma_spi_engine: one instance at DIV=2, one at DIV=1.
module tb_dma_spi_engine;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   acc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dma_spi_engine_if dma2 ();
   dma_spi_engine_if dma1 ();

   logic        z_wr2, z_wr1;
   logic [7:0]  zdata2, zdata1;
   logic        busy2, busy1, sck2, sck1, mosi2, mosi1, miso2, miso1;
   logic [15:0] sdata2, sdata1, cap2, cap1;
   int          falls2 = 0, falls1 = 0, fbase2, fbase1;
   int          rises2 = 0, rises1 = 0, rbase2, rbase1;
   exp_t        q2[$];
   exp_t        q1[$];

   dma_spi_engine #(
      .DIV (2)
   ) u_dut2 (
      .i_clk      (clk),
      .i_rst      (rst),
      .io_dma     (dma2),
      .i_z_wr     (z_wr2),
      .i_zdata    (zdata2),
      .o_z_busy   (busy2),
      .o_spi_sck  (sck2),
      .o_spi_mosi (mosi2),
      .i_spi_miso (miso2)
   );

   dma_spi_engine #(
      .DIV (1)
   ) u_dut1 (
      .i_clk      (clk),
      .i_rst      (rst),
      .io_dma     (dma1),
      .i_z_wr     (z_wr1),
      .i_zdata    (zdata1),
      .o_z_busy   (busy1),
      .o_spi_sck  (sck1),
      .o_spi_mosi (mosi1),
      .i_spi_miso (miso1)
   );

   // Mode-0 slave: bit n of the 16-bit pattern is presented after n falling SCLK edges.
   function automatic logic pick(input logic [15:0] d, input int n);
      logic [15:0] t;
      t = d;
      if (n >= 0 && n < 16) return t[15-n];
      return 1'b1;
   endfunction

   assign miso2 = pick(sdata2, falls2 - fbase2);
   assign miso1 = pick(sdata1, falls1 - fbase1);

   always @(negedge sck2) falls2 <= falls2 + 1;
   always @(negedge sck1) falls1 <= falls1 + 1;
   always @(posedge sck2) begin
      cap2   <= {cap2[14:0], mosi2};
      rises2 <= rises2 + 1;
   end
   always @(posedge sck1) begin
      cap1   <= {cap1[14:0], mosi1};
      rises1 <= rises1 + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon2
      exp_t e;
      if (dma2.spi_stb === 1'b1) begin
         if (q2.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut2 spurious stb: got stb=1 expected none (cycle %0d)", cyc);
         end else begin
            e = q2.pop_front();
            check("dut2 rddata", {24'd0, dma2.spi_rddata}, {24'd0, e.data});
            check("dut2 stb cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (dma1.spi_stb === 1'b1) begin
         if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut1 spurious stb: got stb=1 expected none (cycle %0d)", cyc);
         end else begin
            e = q1.pop_front();
            check("dut1 rddata", {24'd0, dma1.spi_rddata}, {24'd0, e.data});
            check("dut1 stb cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      rst = 1'b1;
      dma2.spi_req = 1'b0; dma2.spi_wrdata = 8'h00; z_wr2 = 1'b0; zdata2 = 8'h00;
      dma1.spi_req = 1'b0; dma1.spi_wrdata = 8'h00; z_wr1 = 1'b0; zdata1 = 8'h00;
      sdata2 = 16'hFFFF; sdata1 = 16'hFFFF;
      fbase2 = 0; fbase1 = 0; rbase2 = 0; rbase1 = 0;
      repeat (3) @(negedge clk);
      check("reset sck", {31'd0, sck2}, 32'd0);
      check("reset mosi", {31'd0, mosi2}, 32'd1);
      check("reset stb", {31'd0, dma2.spi_stb}, 32'd0);
      check("reset rddata", {24'd0, dma2.spi_rddata}, 32'hFF);
      check("reset busy", {31'd0, busy2}, 32'd0);
      check("reset dut1 rddata", {24'd0, dma1.spi_rddata}, 32'hFF);
      rst = 1'b0;
      @(negedge clk);

      // DMA byte A5 at DIV=2, slave returns 3C
      sdata2 = 16'h3C00; fbase2 = falls2; rbase2 = rises2;
      dma2.spi_req = 1'b1; dma2.spi_wrdata = 8'hA5; acc = cyc;
      q2.push_back('{8'h3C, acc + 33});
      @(negedge clk);
      dma2.spi_req = 1'b0;
      check("t1 busy shifting", {31'd0, busy2}, 32'd1);
      repeat (34) @(negedge clk);
      check("t1 mosi byte", {24'd0, cap2[7:0]}, 32'hA5);
      check("t1 rising edges", rises2 - rbase2, 32'd8);
      check("t1 rddata held", {24'd0, dma2.spi_rddata}, 32'h3C);
      check("t1 mosi idle", {31'd0, mosi2}, 32'd1);
      check("t1 busy idle", {31'd0, busy2}, 32'd0);

      // back-to-back DMA bytes 00 then FF at DIV=1
      sdata1 = 16'h5AC3; fbase1 = falls1; rbase1 = rises1;
      dma1.spi_req = 1'b1; dma1.spi_wrdata = 8'h00; acc = cyc;
      q1.push_back('{8'h5A, acc + 17});
      q1.push_back('{8'hC3, acc + 35});
      @(negedge clk);
      dma1.spi_wrdata = 8'hFF;
      repeat (16) @(negedge clk);
      check("t2 rises first byte", rises1 - rbase1, 32'd8);
      check("t2 mosi in done", {31'd0, mosi1}, 32'd1);
      @(negedge clk);
      check("t2 mosi between bytes", {31'd0, mosi1}, 32'd1);
      check("t2 busy with req", {31'd0, busy1}, 32'd1);
      @(negedge clk);
      dma1.spi_req = 1'b0;
      repeat (17) @(negedge clk);
      check("t2 rises both bytes", rises1 - rbase1, 32'd16);
      check("t2 mosi bytes", {16'd0, cap1}, 32'h00FF);
      check("t2 rddata", {24'd0, dma1.spi_rddata}, 32'hC3);
      check("t2 busy idle", {31'd0, busy1}, 32'd0);

      // Z80 byte 81: no stb, rddata still updates
      sdata2 = 16'h6600; fbase2 = falls2; rbase2 = rises2;
      z_wr2 = 1'b1; zdata2 = 8'h81;
      check("t3 busy accept cycle", {31'd0, busy2}, 32'd0);
      @(negedge clk);
      z_wr2 = 1'b0;
      check("t3 busy after accept", {31'd0, busy2}, 32'd1);
      repeat (32) @(negedge clk);
      check("t3 busy in done", {31'd0, busy2}, 32'd1);
      check("t3 no stb in done", {31'd0, dma2.spi_stb}, 32'd0);
      check("t3 rddata", {24'd0, dma2.spi_rddata}, 32'h66);
      @(negedge clk);
      check("t3 busy idle", {31'd0, busy2}, 32'd0);
      check("t3 mosi byte", {24'd0, cap2[7:0]}, 32'h81);
      check("t3 rising edges", rises2 - rbase2, 32'd8);

      // DMA and Z80 in the same cycle: only 22 goes out
      sdata2 = 16'h9900; fbase2 = falls2; rbase2 = rises2;
      dma2.spi_req = 1'b1; dma2.spi_wrdata = 8'h22;
      z_wr2 = 1'b1; zdata2 = 8'h11; acc = cyc;
      q2.push_back('{8'h99, acc + 33});
      @(negedge clk);
      dma2.spi_req = 1'b0; z_wr2 = 1'b0;
      repeat (34) @(negedge clk);
      check("t4 mosi byte", {24'd0, cap2[7:0]}, 32'h22);
      check("t4 rising edges", rises2 - rbase2, 32'd8);
      repeat (40) @(negedge clk);
      check("t4 no z80 transfer", rises2 - rbase2, 32'd8);

      // reset after 5 SCLK edges of F0
      fbase2 = falls2; rbase2 = rises2;
      dma2.spi_req = 1'b1; dma2.spi_wrdata = 8'hF0;
      @(negedge clk);
      dma2.spi_req = 1'b0;
      repeat (10) @(negedge clk);
      check("t5 rises before reset", rises2 - rbase2, 32'd3);
      rst = 1'b1;
      @(negedge clk);
      check("t5 sck after reset", {31'd0, sck2}, 32'd0);
      check("t5 mosi after reset", {31'd0, mosi2}, 32'd1);
      check("t5 rddata after reset", {24'd0, dma2.spi_rddata}, 32'hFF);
      check("t5 busy after reset", {31'd0, busy2}, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      sdata2 = 16'hE700; fbase2 = falls2; rbase2 = rises2;
      dma2.spi_req = 1'b1; dma2.spi_wrdata = 8'h3C; acc = cyc;
      q2.push_back('{8'hE7, acc + 33});
      @(negedge clk);
      dma2.spi_req = 1'b0;
      repeat (34) @(negedge clk);
      check("t5 mosi new byte", {24'd0, cap2[7:0]}, 32'h3C);
      check("t5 rddata new byte", {24'd0, dma2.spi_rddata}, 32'hE7);

      check("dut2 expected stb all seen", q2.size(), 32'd0);
      check("dut1 expected stb all seen", q1.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
